// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sound_pkg
//  Description : Sound codes, per-code durations, urgency test and scheduler
//                state encoding shared by the sound scheduler files.
//  Revision    : 1.0 - initial release
// ============================================================================
package sound_pkg;

    localparam logic [2:0] SND_NONE    = 3'd0;
    localparam logic [2:0] SND_SELECT  = 3'd1;
    localparam logic [2:0] SND_MOVE    = 3'd2;
    localparam logic [2:0] SND_CAPTURE = 3'd3;
    localparam logic [2:0] SND_CHECK   = 3'd4;
    localparam logic [2:0] SND_ILLEGAL = 3'd5;
    localparam logic [2:0] SND_WIN     = 3'd6;
    localparam logic [2:0] SND_MENU    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Length of each sound in milliseconds
    function automatic int unsigned dur_ms(input logic [2:0] code);
        case (code)
            SND_SELECT:  dur_ms = 60;
            SND_MOVE:    dur_ms = 120;
            SND_CAPTURE: dur_ms = 200;
            SND_CHECK:   dur_ms = 300;
            SND_ILLEGAL: dur_ms = 80;
            SND_WIN:     dur_ms = 1000;
            SND_MENU:    dur_ms = 60;
            default:     dur_ms = 0;
        endcase
    endfunction

    // Urgent codes cut off the current sound and discard the backlog
    function automatic logic is_urgent(input logic [2:0] code);
        return (code == SND_CHECK) || (code == SND_WIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sound_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sound_fifo
//  Description : Small synchronous FIFO of sound codes. 'clr' empties it;
//                'load' empties it and leaves din as the single entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module sound_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       clr,
    input  logic                       load,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    import sound_pkg::*;

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd;
    logic [c_PTR_W-1:0] r_wr;
    logic [c_CNT_W-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;
    logic w_load_ok;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign w_load_ok = load && !clr;

    // Pointer/count/storage update; clear (or clear-and-load) overrides push/pop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr || load) begin
            r_rd    <= '0;
            r_wr    <= w_load_ok ? c_PTR_W'(1) : '0;
            r_count <= w_load_ok ? c_CNT_W'(1) : '0;
            if (w_load_ok) begin
                r_mem[0] <= din;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr] <= din;
                r_wr        <= r_wr + c_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd <= r_rd + c_PTR_W'(1);
            end
            if (w_push_ok && !w_pop_ok) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop_ok && !w_push_ok) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sound_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sound_scheduler
//  Description : Queues one-shot sound requests and plays them one at a time
//                on the shared tone player, each for its fixed duration and
//                followed by a silent gap. Urgent codes preempt.
//  Revision    : 1.0 - initial release
// ============================================================================
module sound_scheduler #(
    parameter int TICK_DIV   = 100000,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_MS     = 20
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       req_valid,
    input  logic [2:0] req_code,
    input  logic       flush,
    input  logic       mute,
    output logic       play_sound,
    output logic [2:0] tone_code,
    output logic       busy,
    output logic       dropped,
    output logic [2:0] fifo_count
);
    import sound_pkg::*;

    localparam int c_TIMER_W = $clog2(1000 * TICK_DIV);
    localparam int c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_TIMER_W-1:0] c_GAP_LOAD = c_TIMER_W'(GAP_MS * TICK_DIV - 1);

    state_t               r_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic                 r_play;
    logic [2:0]           r_tone;
    logic                 r_dropped;

    logic [2:0]           w_head;
    logic [c_CNT_W-1:0]   w_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_accept;
    logic                 w_cur_urgent;
    logic                 w_preempt;
    logic                 w_normal;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;

    // Request classification: flush swallows any simultaneous request
    assign w_accept     = req_valid && (req_code != SND_NONE) && !flush;
    assign w_cur_urgent = (r_state == ST_PLAY) && is_urgent(r_tone);
    assign w_preempt    = w_accept && is_urgent(req_code) && !w_cur_urgent;
    assign w_normal     = w_accept && !w_preempt;
    assign w_push       = w_normal && !w_full;
    assign w_drop       = w_normal && w_full;
    // An urgent load in IDLE replaces the head, so hold off the pop that cycle
    assign w_pop        = (r_state == ST_IDLE) && !w_empty && !flush && !w_preempt;

    sound_fifo #(
        .WIDTH (3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (flush),
        .load  (w_preempt),
        .push  (w_push),
        .pop   (w_pop),
        .din   (req_code),
        .dout  (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign play_sound = r_play & ~mute;
    assign tone_code  = r_tone;
    assign dropped    = r_dropped;
    assign fifo_count = 3'(w_count);
    assign busy       = (r_state != ST_IDLE) || (w_count != '0);

    // Playback sequencer: IDLE pops, PLAY times the sound, GAP times the silence
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_play    <= 1'b0;
            r_tone    <= SND_NONE;
            r_dropped <= 1'b0;
        end else begin
            r_dropped <= w_drop;
            if (flush) begin
                r_state <= ST_IDLE;
                r_timer <= '0;
                r_play  <= 1'b0;
                r_tone  <= SND_NONE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_pop) begin
                            r_state <= ST_PLAY;
                            r_play  <= 1'b1;
                            r_tone  <= w_head;
                            r_timer <= c_TIMER_W'(dur_ms(w_head) * TICK_DIV - 1);
                        end
                    end
                    ST_PLAY: begin
                        if (w_preempt || (r_timer == '0)) begin
                            r_state <= ST_GAP;
                            r_play  <= 1'b0;
                            r_timer <= c_GAP_LOAD;
                        end else begin
                            r_timer <= r_timer - c_TIMER_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (r_timer == '0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_timer <= r_timer - c_TIMER_W'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_play  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sound_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sound_scheduler
//  Description : Self-checking bench for sound_scheduler with a queue-based
//                reference model and directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sound_scheduler;

    localparam int TICK  = 10;
    localparam int GAPMS = 2;
    localparam int DEPTH = 4;
    localparam int GAPCY = GAPMS * TICK;

    logic       clk       = 1'b0;
    logic       rstn      = 1'b0;
    logic       req_valid = 1'b0;
    logic [2:0] req_code  = 3'd0;
    logic       flush     = 1'b0;
    logic       mute      = 1'b0;
    logic       play_sound;
    logic [2:0] tone_code;
    logic       busy;
    logic       dropped;
    logic [2:0] fifo_count;

    int n_pass  = 0;
    int n_total = 0;

    sound_scheduler #(
        .TICK_DIV   (TICK),
        .FIFO_DEPTH (DEPTH),
        .GAP_MS     (GAPMS)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_code   (req_code),
        .flush      (flush),
        .mute       (mute),
        .play_sound (play_sound),
        .tone_code  (tone_code),
        .busy       (busy),
        .dropped    (dropped),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         dur_tab [8] = '{0, 60, 120, 200, 300, 80, 1000, 60};
    logic [2:0] m_q [$];
    int         m_play_left = 0;
    int         m_gap_left  = 0;
    logic [2:0] m_tone      = 3'd0;
    logic       m_dropped   = 1'b0;

    function automatic bit urgent(input logic [2:0] c);
        return (c == 3'd4) || (c == 3'd6);
    endfunction

    task automatic model_step();
        bit acc, preempt, drop;
        if (flush) begin
            m_q.delete();
            m_play_left = 0;
            m_gap_left  = 0;
            m_tone      = 3'd0;
            m_dropped   = 1'b0;
        end else begin
            acc     = req_valid && (req_code != 3'd0);
            preempt = acc && urgent(req_code) && !((m_play_left > 0) && urgent(m_tone));
            drop    = acc && !preempt && (m_q.size() == DEPTH);
            m_dropped = drop;
            if (m_play_left > 0) begin
                if (preempt) begin
                    m_play_left = 0;
                    m_gap_left  = GAPCY;
                end else begin
                    m_play_left--;
                    if (m_play_left == 0) m_gap_left = GAPCY;
                end
            end else if (m_gap_left > 0) begin
                m_gap_left--;
            end else if ((m_q.size() > 0) && !preempt) begin
                m_tone      = m_q.pop_front();
                m_play_left = dur_tab[m_tone] * TICK;
            end
            if (preempt) begin
                m_q.delete();
                m_q.push_back(req_code);
            end else if (acc && !drop) begin
                m_q.push_back(req_code);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            if (!rstn) begin
                m_q.delete();
                m_play_left = 0;
                m_gap_left  = 0;
                m_tone      = 3'd0;
                m_dropped   = 1'b0;
            end else begin
                model_step();
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    endtask

    // Per-cycle compare of {play_sound, tone_code, busy, dropped, fifo_count}
    initial begin
        logic [8:0] act, exp;
        forever begin
            @(negedge clk);
            act = {play_sound, tone_code, busy, dropped, fifo_count};
            exp = {(m_play_left > 0) && !mute, m_tone,
                   (m_play_left > 0) || (m_gap_left > 0) || (m_q.size() > 0),
                   m_dropped, 3'(m_q.size())};
            check("cycle", int'(act), int'(exp));
        end
    end

    // Records every audible sound as (tone, length) and counts dropped pulses
    logic [2:0] snd_tone [$];
    int         snd_len  [$];
    int         n_drops = 0;
    initial begin
        int         len = 0;
        logic [2:0] cur = 3'd0;
        forever begin
            @(negedge clk);
            if (dropped) n_drops++;
            if (play_sound) begin
                len++;
                cur = tone_code;
            end else if (len > 0) begin
                snd_tone.push_back(cur);
                snd_len.push_back(len);
                len = 0;
            end
        end
    end

    task automatic expect_sound(input string name, input int idx, input int tone, input int len);
        if (idx < snd_len.size()) begin
            check({name, "_tone"}, int'(snd_tone[idx]), tone);
            check({name, "_len"}, snd_len[idx], len);
        end else begin
            check({name, "_present"}, snd_len.size(), idx + 1);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input logic [2:0] code);
        req_valid = 1'b1;
        req_code  = code;
        step(1);
        req_valid = 1'b0;
        req_code  = 3'd0;
    endtask

    task automatic wait_idle(input string name, input int budget, output int cyc);
        cyc = 0;
        while (busy && (cyc < budget)) begin
            step(1);
            cyc++;
        end
        if (busy) check({name, "_idle_timeout"}, int'(busy), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- scenarios ----------------
    initial begin
        int cyc, base, dbase;

        step(3);
        rstn = 1'b1;
        step(1);
        check("rst_play", int'(play_sound), 0);
        check("rst_tone", int'(tone_code), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_dropped", int'(dropped), 0);

        // Single move sound: 2-cycle start latency, 1200 high, 20 gap
        base = snd_len.size();
        send(3'd2);
        check("t1_play_lat", int'(play_sound), 0);
        check("t1_count_push", int'(fifo_count), 1);
        step(1);
        check("t1_play_on", int'(play_sound), 1);
        check("t1_tone", int'(tone_code), 2);
        wait_idle("t1", 5000, cyc);
        check("t1_cycles_to_idle", cyc, 1220);
        expect_sound("t1_s0", base, 2, 1200);

        // Three back-to-back requests play in order
        base  = snd_len.size();
        dbase = n_drops;
        send(3'd1);
        check("t2_count_a", int'(fifo_count), 1);
        send(3'd2);
        check("t2_count_b", int'(fifo_count), 1);
        send(3'd3);
        check("t2_count_peak", int'(fifo_count), 2);
        wait_idle("t2", 10000, cyc);
        expect_sound("t2_s0", base, 1, 600);
        expect_sound("t2_s1", base + 1, 2, 1200);
        expect_sound("t2_s2", base + 2, 3, 2000);
        check("t2_drops", n_drops - dbase, 0);

        // Overflow while the win sound plays
        base  = snd_len.size();
        dbase = n_drops;
        send(3'd6);
        step(5);
        for (int i = 0; i < 5; i++) send(3'd1);
        check("t3_dropped_pulse", int'(dropped), 1);
        check("t3_count_full", int'(fifo_count), 4);
        wait_idle("t3", 20000, cyc);
        check("t3_drops", n_drops - dbase, 1);
        check("t3_nsounds", snd_len.size() - base, 5);
        expect_sound("t3_win", base, 6, 10000);
        for (int i = 1; i <= 4; i++) expect_sound("t3_sel", base + i, 1, 600);

        // Urgent preemption of a non-urgent sound with backlog
        base = snd_len.size();
        send(3'd3);
        step(10);
        send(3'd1);
        send(3'd2);
        check("t4_backlog", int'(fifo_count), 2);
        send(3'd6);
        check("t4_play_cut", int'(play_sound), 0);
        check("t4_count_sole", int'(fifo_count), 1);
        wait_idle("t4", 20000, cyc);
        check("t4_nsounds", snd_len.size() - base, 2);
        expect_sound("t4_cut", base, 3, 12);
        expect_sound("t4_win", base + 1, 6, 10000);

        // Muted check sound: timing runs, output stays low
        base = snd_len.size();
        mute = 1'b1;
        send(3'd4);
        step(1);
        check("t5_muted_play", int'(play_sound), 0);
        check("t5_muted_tone", int'(tone_code), 4);
        step(2999);
        check("t5_tone_end", int'(tone_code), 4);
        mute = 1'b0;
        #1;
        check("t5_unmute_live", int'(play_sound), 1);
        mute = 1'b1;
        step(1);
        check("t5_after_dur", int'(play_sound), 0);
        wait_idle("t5", 5000, cyc);
        check("t5_no_audible", snd_len.size() - base, 0);

        // Flush mid-sound with a simultaneous request
        dbase = n_drops;
        send(3'd5);
        step(50);
        flush     = 1'b1;
        req_valid = 1'b1;
        req_code  = 3'd2;
        step(1);
        flush     = 1'b0;
        req_valid = 1'b0;
        req_code  = 3'd0;
        check("t5_flush_busy", int'(busy), 0);
        check("t5_flush_count", int'(fifo_count), 0);
        check("t5_flush_tone", int'(tone_code), 0);
        step(1);
        check("t5_flush_nodrop", n_drops - dbase, 0);
        check("t5_flush_stays_idle", int'(busy), 0);
        mute = 1'b0;

        // Asynchronous reset in the middle of a sound
        send(3'd7);
        step(30);
        #1 rstn = 1'b0;
        #1;
        check("t6_rst_play", int'(play_sound), 0);
        check("t6_rst_tone", int'(tone_code), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_count", int'(fifo_count), 0);
        step(2);
        rstn = 1'b1;
        step(2);
        base = snd_len.size();
        send(3'd1);
        wait_idle("t6", 5000, cyc);
        expect_sound("t6_after", base, 1, 600);

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
